// File: rtl/decode_execute_skid_register.sv
// Decode/execute pipeline register with a 2-entry skid buffer.
// Registered ready, flush with bubble insertion, saturating perf counters.
module decode_execute_skid_register #(
  parameter int                 CTRL_W      = 14,
  parameter int                 PAYLOAD_W   = 116,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
  parameter int                 CNT_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [CTRL_W-1:0]    ctrl_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [CTRL_W-1:0]    ctrl_o,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic [1:0]           occupancy_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                 in_ready_q;
  logic                 in_ready_d;
  logic [CTRL_W-1:0]    main_ctrl_q, main_ctrl_d;
  logic [PAYLOAD_W-1:0] main_pay_q, main_pay_d;
  logic [CTRL_W-1:0]    skid_ctrl_q, skid_ctrl_d;
  logic [PAYLOAD_W-1:0] skid_pay_q, skid_pay_d;
  logic [CNT_W-1:0]     stall_q;
  logic [CNT_W-1:0]     flush_q;

  logic accept;
  logic fire;
  logic stall;

  assign out_valid_o = (state_q != EMPTY);
  assign accept      = in_valid_i & in_ready_q & ~flush_i;
  assign fire        = out_valid_o & out_ready_i;
  assign stall       = out_valid_o & ~out_ready_i;

  // State encoding doubles as the entry count.
  assign occupancy_o = state_q;
  assign in_ready_o  = in_ready_q;
  assign ctrl_o      = out_valid_o ? main_ctrl_q : BUBBLE_CTRL;
  assign payload_o   = main_pay_q;
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_pay_d  = main_pay_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_pay_d  = skid_pay_q;
    if (flush_i) begin
      // Data is kept; only occupancy collapses.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_ctrl_d = ctrl_i;
            main_pay_d  = payload_i;
          end
        end
        ONE: begin
          if (accept && fire) begin
            main_ctrl_d = ctrl_i;
            main_pay_d  = payload_i;
          end else if (accept) begin
            state_d     = FULL;
            skid_ctrl_d = ctrl_i;
            skid_pay_d  = payload_i;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (fire) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_pay_d  = skid_pay_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_pay_q  <= '0;
      skid_ctrl_q <= '0;
      skid_pay_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_pay_q  <= main_pay_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_pay_q  <= skid_pay_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && !(&stall_q))
        stall_q <= stall_q + CNT_W'(1);
      if (flush_i && !(&flush_q))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_execute_skid_register.sv
// Scoreboard bench: a FIFO-of-entries reference model checked every cycle.
// Directed scenarios first, then randomized traffic with flushes.
module tb_decode_execute_skid_register;

  localparam int CW = 14;
  localparam int PW = 116;
  localparam int NW = 4;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [PW-1:0] p;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [CW-1:0] ctrl_i = '0;
  logic [PW-1:0] payload_i = '0;
  logic          flush_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [CW-1:0] ctrl_o;
  logic [PW-1:0] payload_o;
  logic [1:0]    occupancy_o;
  logic [NW-1:0] stall_cnt_o;
  logic [NW-1:0] flush_cnt_o;

  decode_execute_skid_register #(
    .CTRL_W(CW),
    .PAYLOAD_W(PW),
    .BUBBLE_CTRL('0),
    .CNT_W(NW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .ctrl_i(ctrl_i),
    .payload_i(payload_i),
    .flush_i(flush_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .ctrl_o(ctrl_o),
    .payload_o(payload_o),
    .occupancy_o(occupancy_o),
    .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  ent_t          q[$];
  int            checks = 0;
  int            errors = 0;
  logic [NW-1:0] exp_stall = '0;
  logic [NW-1:0] exp_flush = '0;
  logic [PW-1:0] stale = '0;
  logic          dummy;

  task automatic check(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rp();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  // Monitor: compare presented state, then advance the model one edge.
  always @(negedge clk) begin
    int n;
    n = q.size();
    check("out_valid", 128'(out_valid_o), 128'(n > 0));
    check("in_ready", 128'(in_ready_o), 128'(n < 2));
    check("occupancy", 128'(occupancy_o), 128'(n));
    check("ctrl", 128'(ctrl_o), 128'(n > 0 ? q[0].c : CW'(0)));
    check("payload", 128'(payload_o), 128'(n > 0 ? q[0].p : stale));
    check("stall_cnt", 128'(stall_cnt_o), 128'(exp_stall));
    check("flush_cnt", 128'(flush_cnt_o), 128'(exp_flush));
    if (!rst_i) begin
      if (n > 0 && !out_ready_i && exp_stall != '1)
        exp_stall = exp_stall + 1'b1;
      if (flush_i && exp_flush != '1)
        exp_flush = exp_flush + 1'b1;
      if (flush_i) begin
        if (n > 0) stale = q[0].p;
        q.delete();
      end else if (n > 0 && out_ready_i) begin
        stale = q[0].p;
        void'(q.pop_front());
      end
    end
  end

  task automatic step(input logic v, input logic [CW-1:0] c,
                      input logic [PW-1:0] p, input logic rdy,
                      input logic fl, output logic acc);
    ent_t e;
    @(posedge clk);
    #1;
    in_valid_i  = v;
    ctrl_i      = c;
    payload_i   = p;
    out_ready_i = rdy;
    flush_i     = fl;
    @(negedge clk);
    #1;
    acc = !rst_i && v && in_ready_o && !fl;
    if (acc) begin
      e.c = c;
      e.p = p;
      q.push_back(e);
    end
  endtask

  task automatic idle(input logic rdy, input int k);
    for (int i = 0; i < k; i++)
      step(1'b0, CW'($urandom), rp(), rdy, 1'b0, dummy);
  endtask

  // Reset lands between edges; outputs must settle with no clock.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_valid", 128'(out_valid_o), 128'(0));
    check("rst_ready", 128'(in_ready_o), 128'(1));
    check("rst_occ", 128'(occupancy_o), 128'(0));
    check("rst_ctrl", 128'(ctrl_o), 128'(0));
    check("rst_payload", 128'(payload_o), 128'(0));
    check("rst_stall", 128'(stall_cnt_o), 128'(0));
    check("rst_flush", 128'(flush_cnt_o), 128'(0));
    q.delete();
    exp_stall  = '0;
    exp_flush  = '0;
    stale      = '0;
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    logic acc;
    int   k;
    #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Streaming at full rate
    for (int i = 1; i <= 8; i++)
      step(1'b1, CW'($urandom), PW'(i), 1'b1, 1'b0, dummy);
    idle(1'b1, 3);

    // Backpressure: A, B fill, C waits
    step(1'b1, CW'($urandom), PW'('h11), 1'b0, 1'b0, dummy);
    step(1'b1, CW'($urandom), PW'('h22), 1'b0, 1'b0, dummy);
    for (int i = 0; i < 3; i++)
      step(1'b1, CW'(14'h0C3), PW'('h33), 1'b0, 1'b0, dummy);
    k = 0;
    acc = 1'b0;
    while (!acc && k < 10) begin
      step(1'b1, CW'(14'h0C3), PW'('h33), 1'b1, 1'b0, acc);
      k++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_c: got none expected accept in 10 cycles");
    end
    idle(1'b1, 4);

    // Flush while full, D dropped
    step(1'b1, CW'($urandom), PW'('hA), 1'b0, 1'b0, dummy);
    step(1'b1, CW'($urandom), PW'('hB), 1'b0, 1'b0, dummy);
    step(1'b1, CW'($urandom), PW'('hD), 1'b0, 1'b1, dummy);
    idle(1'b1, 3);

    // Control gating
    step(1'b1, CW'(14'h3FFF), PW'('hABC), 1'b1, 1'b0, dummy);
    idle(1'b1, 3);

    // Async reset while full, then 1-cycle latency
    step(1'b1, CW'($urandom), rp(), 1'b0, 1'b0, dummy);
    step(1'b1, CW'($urandom), rp(), 1'b0, 1'b0, dummy);
    idle(1'b0, 1);
    do_reset();
    step(1'b1, CW'($urandom), PW'('h55), 1'b1, 1'b0, dummy);
    idle(1'b1, 2);

    // Stall counter saturation
    do_reset();
    step(1'b1, CW'($urandom), PW'('h66), 1'b0, 1'b0, dummy);
    idle(1'b0, 20);
    check("stall_sat", 128'(stall_cnt_o), 128'(4'hF));
    idle(1'b1, 3);

    // Randomized traffic with occasional flushes
    do_reset();
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), CW'($urandom), rp(),
           1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 19) == 0), dummy);
    idle(1'b1, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_execute_skid_register.md
Name: decode_execute_skid_register

Overview:
- Parametrised decode/execute pipeline register for the next core revision.
- Separates a control field (alusrc, mem_to_reg, reg_write, reg_dest, mem_read, mem_write, isbranchtaken, jump, alu_op) from a data payload (opcode, funct3, rs1, rs2, read_data1, read_data2, offset).
- Uses a valid/ready handshake with a 2-entry skid buffer, so execute-stage stalls never create a combinational ready path back into decode.
- Provides synchronous flush with bubble insertion for branch/jump redirects, plus saturating stall and flush counters.

Parameters:
- CTRL_W, 14, width of control bundle (8 single-bit flags + 6-bit alu_op).
- PAYLOAD_W, 116, width of data bundle (7+3+5+5+32+32+32).
- BUBBLE_CTRL, 14'b0, control value driven whenever no valid entry is presented; must make the instruction architecturally inert.
- CNT_W, 16, width of each performance counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  decode presents an instruction.
- in_ready_o  out  1  register can accept; driven directly from a flop.
- ctrl_i  in  CTRL_W  control bundle from decode.
- payload_i  in  PAYLOAD_W  data bundle from decode.
- flush_i  in  1  discard all held and incoming entries.
- out_valid_o  out  1  execute-side entry valid.
- out_ready_i  in  1  execute accepts the entry.
- ctrl_o  out  CTRL_W  control to execute; BUBBLE_CTRL when out_valid_o=0.
- payload_o  out  PAYLOAD_W  data to execute.
- occupancy_o  out  2  entries held: 0, 1 or 2.
- stall_cnt_o  out  CNT_W  saturating count of stall cycles.
- flush_cnt_o  out  CNT_W  saturating count of flush cycles.

Behaviour:
- Storage: a main entry drives the outputs; a skid entry holds overflow. Each has a valid bit. Order is strictly FIFO.
- accept = in_valid_i & in_ready_o & ~flush_i.
- fire = out_valid_o & out_ready_i.
- in_ready_o = ~skid_valid, registered.
- State EMPTY (occupancy 0):
  - accept -> ONE, main <= input.
  - otherwise stay in EMPTY.
- State ONE (occupancy 1):
  - accept & fire -> ONE, main <= input.
  - accept & ~fire -> FULL, skid <= input, main holds.
  - ~accept & fire -> EMPTY.
  - otherwise hold.
- State FULL (occupancy 2):
  - in_ready_o=0, so no accept.
  - fire -> ONE, main <= skid, skid invalidated.
  - otherwise hold.
- Latency: 1 cycle from accept into EMPTY to out_valid_o. Throughput: 1 instruction/cycle when out_ready_i is held high.
- Control gating: ctrl_o = out_valid_o ? main_ctrl : BUBBLE_CTRL (combinational mux on registered state). payload_o always shows main_payload, including stale data when invalid.
- Flush (highest priority):
  - On a clock edge with flush_i=1, both valid bits clear, state -> EMPTY, in_ready_o -> 1.
  - Input offered in the same cycle is dropped, even though in_ready_o may read 1.
  - A fire in the flush cycle still counts as completed for the downstream.
- Simultaneous flush_i and rst_i: reset dominates.
- Payload data registers are not cleared on flush; only the valid bits are.
- stall_cnt_o: +1 on each edge where out_valid_o=1 and out_ready_i=0; saturates at all-ones.
- flush_cnt_o: +1 on each edge where flush_i=1, regardless of occupancy; saturates at all-ones.
- Reset (async assert, sampled release):
  - out_valid_o=0, in_ready_o=1, occupancy_o=0.
  - ctrl_o=BUBBLE_CTRL, payload_o=0.
  - stall_cnt_o=0, flush_cnt_o=0, skid contents=0.
  - Reset asserted mid-operation discards all entries immediately, with no clock required.
- No X propagation: every flop has a reset value.

Test Plan:
- Streaming: rst, then 8 back-to-back inputs with payload=1..8 and out_ready_i=1 -> outputs 1..8 on consecutive cycles, each 1 cycle after its input; occupancy_o stays at 1; stall_cnt_o=0.
- Backpressure: out_ready_i=0 while sending A=0x11, B=0x22 -> occupancy_o reaches 2 and in_ready_o=0 on the next cycle; C is held at input. Release out_ready_i -> output order A, B, C; stall_cnt_o equals the number of cycles out_valid_o was high with ready low.
- Flush while full: FULL with A,B, pulse flush_i for 1 cycle with in_valid_i=1 carrying D -> next cycle out_valid_o=0, ctrl_o=BUBBLE_CTRL, occupancy_o=0, in_ready_o=1, D never appears, flush_cnt_o=1.
- Control gating: send ctrl=14'h3FFF, drain it, leave idle -> ctrl_o=14'h0000 while out_valid_o=0; payload_o retains the last value.
- Async reset mid-stream: assert rst_i between clock edges while occupancy=2 -> all outputs reach their reset values before the next edge; first input after release appears with 1-cycle latency.
- Counter saturation: CNT_W=4, hold out_valid_o=1 and out_ready_i=0 for 20 cycles -> stall_cnt_o stops at 4'hF.
